// File: rtl/rr_arb16_sched_pkg.sv
// Shared definitions for the 16-way round-robin arbiter/scheduler.
//   state_e  : FSM encoding (IDLE / BUSY / GAP)
//   NREQ     : number of requesters
//   IDX_W    : width of a requester index
//   ffs_idx  : index of the lowest set bit of a 16-bit vector (0 if none)
package rr_arb16_sched_pkg;

   localparam int unsigned NREQ  = 16;
   localparam int unsigned IDX_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Fixed-priority find-first: bit 0 has the highest priority.
   function automatic logic [IDX_W-1:0] ffs_idx(input logic [NREQ-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/onehot_dec4_16.sv
// 4-to-16 one-hot decoder with enable.
//   idx      in  4   index to decode
//   en       in  1   1 = drive the selected bit, 0 = all-zero output
//   onehot_c out 16  combinational one-hot (or zero) result
module onehot_dec4_16
   import rr_arb16_sched_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [NREQ-1:0]  onehot_c
);

   always_comb begin
      onehot_c = '0;
      if (en) onehot_c[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arb16_sched.sv
// Round-robin arbiter/scheduler sharing one resource among 16 requesters.
// A winner is picked in IDLE, owns the resource in BUSY until it releases,
// withdraws its request or hits MAX_HOLD cycles, then one GAP cycle of bus
// turnaround precedes the next arbitration.
//   clk      in   1   rising-edge clock
//   rst_n    in   1   async active-low reset
//   en       in   1   allows new grants (does not revoke a running grant)
//   req      in   16  level requests, bit k = requester k
//   done     in   1   owner releases the resource (only looked at in BUSY)
//   gnt      out  16  one-hot grant, decode of gnt_id gated by gnt_vld
//   gnt_id   out  4   index of the current owner
//   gnt_vld  out  1   a grant is active
//   timeout  out  1   one-cycle pulse after a forced release at MAX_HOLD
module rr_arb16_sched
   import rr_arb16_sched_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_id,
   output logic             gnt_vld,
   output logic             timeout
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   hold_q, hold_d;
   logic [IDX_W-1:0]   gnt_id_d;
   logic               gnt_vld_d;
   logic               timeout_d;

   logic [NREQ-1:0]    req_rot;
   logic [IDX_W-1:0]   win_idx;
   logic               at_max;
   logic               release_c;

   // Rotate requests so that requester ptr lands on bit 0.
   always_comb begin
      req_rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_rot[i] = req[IDX_W'(i) + ptr_q];
      end
   end

   // Find-first in rotated space, then map back; 4-bit add wraps mod 16.
   assign win_idx = ptr_q + ffs_idx(req_rot);

   assign at_max    = (hold_q == CNT_W'(MAX_HOLD));
   assign release_c = done | ~req[gnt_id] | at_max;

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_id  <= '0;
         gnt_vld <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_id  <= gnt_id_d;
         gnt_vld <= gnt_vld_d;
         timeout <= timeout_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gnt_id_d  = gnt_id;
      gnt_vld_d = gnt_vld;
      timeout_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (en && (req != '0)) begin
               state_d   = ST_BUSY;
               gnt_id_d  = win_idx;
               gnt_vld_d = 1'b1;
               hold_d    = CNT_W'(1);
            end
         end

         ST_BUSY: begin
            if (release_c) begin
               state_d   = ST_GAP;
               gnt_vld_d = 1'b0;
               gnt_id_d  = '0;
               ptr_d     = gnt_id + IDX_W'(1);
               hold_d    = '0;
               // An owner that signals done in the last allowed cycle is not timed out.
               timeout_d = at_max & ~done;
            end else if (!at_max) begin
               hold_d = hold_q + CNT_W'(1);
            end
         end

         ST_GAP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d   = ST_IDLE;
            gnt_vld_d = 1'b0;
            gnt_id_d  = '0;
            hold_d    = '0;
         end
      endcase
   end

   // Grant lines: decode of the registered owner index.
   onehot_dec4_16 u_gnt_dec (
      .idx      (gnt_id),
      .en       (gnt_vld),
      .onehot_c (gnt)
   );

endmodule

// File: tb/tb_rr_arb16_sched.sv
// Directed self-checking bench for rr_arb16_sched (MAX_HOLD = 4).
module tb_rr_arb16_sched;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] req;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  gnt_id;
   logic        gnt_vld;
   logic        timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   rr_arb16_sched #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_grant(input string tag, input logic [3:0] id);
      logic [15:0] one;
      one = 16'h0001;
      chk({tag, "_vld"}, 32'(gnt_vld), 32'd1);
      chk({tag, "_id"},  32'(gnt_id),  32'(id));
      chk({tag, "_gnt"}, 32'(gnt),     32'(one << id));
   endtask

   task automatic chk_idle(input string tag, input logic to_exp);
      chk({tag, "_vld"}, 32'(gnt_vld), 32'd0);
      chk({tag, "_gnt"}, 32'(gnt),     32'd0);
      chk({tag, "_to"},  32'(timeout), 32'(to_exp));
   endtask

   // Structural invariants, sampled away from the active edge.
   always @(negedge clk) begin
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_vld_gnt", 32'(gnt_vld), 32'(gnt != 16'h0));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 16'hFFFF;
      done  = 1'b0;

      // 1. reset state, then first grant to requester 0
      tick();
      tick();
      chk_idle("rst", 1'b0);
      chk("rst_id", 32'(gnt_id), 32'd0);
      rst_n = 1'b1;
      en    = 1'b1;
      tick();
      chk_grant("first", 4'd0);

      // 2. full rotation 0..15,0 with done each BUSY cycle
      for (int k = 0; k <= 16; k++) begin
         chk_grant("rot", 4'(k % 16));
         done = 1'b1;
         tick();
         chk_idle("rot_gap", 1'b0);
         done = 1'b0;
         tick();
         chk_idle("rot_idle", 1'b0);
         tick();
      end
      chk_grant("rot_next", 4'd1);

      // 3. steer ptr to 14 via requester 13, then wrap-around search
      req = 16'h2000;
      tick();
      chk_idle("wd_gap", 1'b0);
      tick();
      tick();
      chk_grant("g13", 4'd13);
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 16'h0009;
      tick();
      tick();
      chk_grant("wrap0", 4'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      tick();
      chk_grant("after_wrap3", 4'd3);

      // 4. hold timeout with a single requester
      req = 16'h0020;
      tick();
      chk_idle("wd3_gap", 1'b0);
      tick();
      tick();
      chk_grant("hold1", 4'd5);
      tick();
      chk_grant("hold2", 4'd5);
      tick();
      chk_grant("hold3", 4'd5);
      tick();
      chk_grant("hold4", 4'd5);
      chk("hold4_to", 32'(timeout), 32'd0);
      tick();
      chk_idle("to_gap", 1'b1);
      tick();
      chk_idle("to_idle", 1'b0);
      tick();
      chk_grant("regrant5", 4'd5);

      // 5. en=0 keeps a running grant, blocks new ones; done+timeout together
      en = 1'b0;
      tick();
      chk_grant("en0_busy", 4'd5);
      tick();
      done = 1'b1;
      tick();
      chk_idle("en0_rel", 1'b0);
      done = 1'b0;
      tick();
      tick();
      chk_idle("en0_blk1", 1'b0);
      tick();
      chk_idle("en0_blk2", 1'b0);
      en = 1'b1;
      tick();
      chk_grant("en1_grant", 4'd5);
      tick();
      tick();
      tick();
      chk_grant("dt_hold4", 4'd5);
      done = 1'b1;
      tick();
      chk_idle("done_to", 1'b0);
      done = 1'b0;

      // 6. async reset mid-grant, pointer back to 0
      req = 16'h0F0C;
      tick();
      tick();
      chk_grant("pre_rst", 4'd8);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("async_rst", 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_grant("post_rst", 4'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
